// File: rtl/regbank8_rd2_pkg.sv
// Shared CPU types and constants for the decode-stage register bank,
// plus the per-bit 8:1 read-select mux used on every read port.
package regbank8_rd2_pkg;

  localparam int NUM_REGS     = 8;
  localparam int ZERO_REG_IDX = 7;
  localparam int WORD_W       = 64;

  typedef logic [2:0]        reg_idx_t;
  typedef logic [WORD_W-1:0] word_t;

  // One output bit selected from eight entry bits; every 3-bit code is decoded.
  function automatic logic mux8_bit(input logic [7:0] ins, input reg_idx_t sel);
    return ins[sel];
  endfunction

endpackage

// File: rtl/regbank8_rd2_decoder3to8.sv
// One-hot 3:8 decoder with enable; drives the write-enable lines of the bank.
module decoder3to8
  import regbank8_rd2_pkg::*;
(
  input  reg_idx_t   in,
  input  logic       en,
  output logic [7:0] out
);

  always_comb begin
    out = '0;
    if (en) out[in] = 1'b1;
  end

endmodule

// File: rtl/regbank8_rd2.sv
// Eight-entry, one-write/two-read register bank with a hardwired zero entry
// and optional same-cycle write-to-read forwarding.
module regbank8_rd2
  import regbank8_rd2_pkg::*;
#(
  parameter int WIDTH    = WORD_W,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = ZERO_REG_IDX
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  reg_idx_t         wr_reg,
  input  logic [WIDTH-1:0] wr_data,
  input  reg_idx_t         rd_reg1,
  input  reg_idx_t         rd_reg2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2
);

  // No handshake: a write is accepted every cycle wr_en is high and both read
  // ports always present data; stalling is handled by the surrounding pipeline.

  localparam reg_idx_t   ZERO_IDX  = reg_idx_t'(ZERO_REG);
  localparam logic [7:0] ZERO_MASK = 8'(1) << ZERO_IDX;

  logic [NUM_REGS-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [7:0]                     dec_raw;
  logic [7:0]                     we_line;
  logic [WIDTH-1:0]               mux1, mux2;

  decoder3to8 u_wr_dec (
    .in  (wr_reg),
    .en  (wr_en),
    .out (dec_raw)
  );

  assign we_line = dec_raw & ~ZERO_MASK;

  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (we_line[i]) regs_d[i] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) regs_q <= '0;
    else          regs_q <= regs_d;
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_rd_bit
    logic [7:0] ins;
    always_comb begin
      ins = '0;
      for (int i = 0; i < NUM_REGS; i++) ins[i] = regs_q[i][b];
    end
    assign mux1[b] = mux8_bit(ins, rd_reg1);
    assign mux2[b] = mux8_bit(ins, rd_reg2);
  end

  // Zero register and reset dominate; forwarding only overrides stored data.
  always_comb begin
    rd_data1 = mux1;
    if (!reset_n || rd_reg1 == ZERO_IDX)
      rd_data1 = '0;
    else if (BYPASS != 0 && wr_en && wr_reg == rd_reg1)
      rd_data1 = wr_data;
  end

  always_comb begin
    rd_data2 = mux2;
    if (!reset_n || rd_reg2 == ZERO_IDX)
      rd_data2 = '0;
    else if (BYPASS != 0 && wr_en && wr_reg == rd_reg2)
      rd_data2 = wr_data;
  end

endmodule

// File: tb/tb_regbank8_rd2.sv
// Directed bench for regbank8_rd2: table of vectors plus hand-written
// reset, bypass and zero-register sequences; a BYPASS=0 copy shares the inputs.
`timescale 1ns/1ps
module tb_regbank8_rd2;
  import regbank8_rd2_pkg::*;

  logic     clk = 1'b0;
  logic     reset_n;
  logic     wr_en;
  reg_idx_t wr_reg;
  word_t    wr_data;
  reg_idx_t rd_reg1, rd_reg2;
  word_t    rd_data1, rd_data2;
  word_t    nb_data1, nb_data2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic     wr_en;
    reg_idx_t wr_reg;
    word_t    wr_data;
    reg_idx_t rd1;
    reg_idx_t rd2;
    word_t    exp1;
    word_t    exp2;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  regbank8_rd2 #(.WIDTH(64), .BYPASS(1), .ZERO_REG(7)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_reg(wr_reg),
    .wr_data(wr_data), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .rd_data1(rd_data1), .rd_data2(rd_data2)
  );

  regbank8_rd2 #(.WIDTH(64), .BYPASS(0), .ZERO_REG(7)) dut_nb (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_reg(wr_reg),
    .wr_data(wr_data), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .rd_data1(nb_data1), .rd_data2(nb_data2)
  );

  task automatic check(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 3ns later.
  task automatic drive(input logic en, input reg_idx_t wr, input word_t d,
                       input reg_idx_t r1, input reg_idx_t r2);
    @(posedge clk);
    #1;
    wr_en = en; wr_reg = wr; wr_data = d; rd_reg1 = r1; rd_reg2 = r2;
    #3;
  endtask

  function automatic word_t pat(input int i);
    return word_t'(64'h1111_1111_1111_1111 * word_t'(i + 1));
  endfunction

  function automatic vec_t mk(input logic en, input reg_idx_t wr, input word_t d,
                              input reg_idx_t r1, input reg_idx_t r2,
                              input word_t e1, input word_t e2);
    vec_t v;
    v.wr_en = en; v.wr_reg = wr; v.wr_data = d;
    v.rd1 = r1; v.rd2 = r2; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_reg = '0; wr_data = '0; rd_reg1 = '0; rd_reg2 = '0;

    // Writes of pattern i to r[i]; port 1 sees it forwarded, port 2 reads r7.
    for (int i = 0; i < 7; i++)
      vecs.push_back(mk(1'b1, reg_idx_t'(i), pat(i), reg_idx_t'(i), 3'd7, pat(i), 64'h0));
    // Zero-register write attempt, observed during the write cycle.
    vecs.push_back(mk(1'b1, 3'd7, 64'hDEAD_BEEF_0000_0001, 3'd7, 3'd7, 64'h0, 64'h0));
    // Readback sweep: port 1 ascending, port 2 descending.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b0, 3'd0, 64'h0, reg_idx_t'(i), reg_idx_t'(7 - i),
                        (i == 7) ? 64'h0 : pat(i), (i == 0) ? 64'h0 : pat(7 - i)));

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i += 2) begin
      rd_reg1 = reg_idx_t'(i); rd_reg2 = reg_idx_t'(i + 1);
      #0.5;
      check("reset_rd1", rd_data1, 64'h0);
      check("reset_rd2", rd_data2, 64'h0);
    end
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].wr_en, vecs[k].wr_reg, vecs[k].wr_data, vecs[k].rd1, vecs[k].rd2);
      check($sformatf("vec%0d_rd1", k), rd_data1, vecs[k].exp1);
      check($sformatf("vec%0d_rd2", k), rd_data2, vecs[k].exp2);
    end

    // Bypass: both ports on the register being written.
    drive(1'b1, 3'd3, 64'hA5, 3'd0, 3'd0);
    drive(1'b1, 3'd3, 64'h5A, 3'd3, 3'd3);
    check("byp_rd1", rd_data1, 64'h5A);
    check("byp_rd2", rd_data2, 64'h5A);
    check("nobyp_rd1", nb_data1, 64'hA5);
    check("nobyp_rd2", nb_data2, 64'hA5);
    drive(1'b0, 3'd0, 64'h0, 3'd3, 3'd3);
    check("byp_stored", rd_data1, 64'h5A);
    check("nobyp_stored", nb_data2, 64'h5A);

    // wr_en low: neither storage nor forwarding changes.
    drive(1'b1, 3'd2, 64'h10, 3'd0, 3'd1);
    drive(1'b0, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 3'd2, 3'd2);
    check("wren0_nofwd", rd_data1, 64'h10);
    drive(1'b0, 3'd0, 64'h0, 3'd2, 3'd7);
    check("wren0_kept", rd_data1, 64'h10);
    check("zero_after", rd_data2, 64'h0);

    // Short reset pulse between edges; a write shown during it is dropped.
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    wr_en = 1'b1; wr_reg = 3'd1; wr_data = 64'hBAD;
    for (int i = 0; i < 8; i += 2) begin
      rd_reg1 = reg_idx_t'(i); rd_reg2 = reg_idx_t'(i + 1);
      #0.5;
      check("pulse_rd1", rd_data1, 64'h0);
      check("pulse_rd2", rd_data2, 64'h0);
    end
    #1;
    wr_en = 1'b0;
    reset_n = 1'b1;
    drive(1'b0, 3'd0, 64'h0, 3'd1, 3'd2);
    check("pulse_nowrite", rd_data1, 64'h0);
    check("pulse_cleared", rd_data2, 64'h0);

    // Reset asserted during a write to r5, then a write on the first edge after release.
    drive(1'b1, 3'd5, 64'h77, 3'd0, 3'd0);
    drive(1'b1, 3'd5, 64'h99, 3'd5, 3'd5);
    check("mid_fwd", rd_data1, 64'h99);
    reset_n = 1'b0;
    #0.5;
    check("mid_rst_rd", rd_data1, 64'h0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    #1;
    check("mid_rst_held", rd_data2, 64'h0);
    reset_n = 1'b1;
    wr_en = 1'b1; wr_reg = 3'd5; wr_data = 64'h123; rd_reg1 = 3'd0; rd_reg2 = 3'd0;
    drive(1'b0, 3'd0, 64'h0, 3'd5, 3'd5);
    check("post_rst_write", rd_data1, 64'h123);
    check("post_rst_nb", nb_data2, 64'h123);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded 20000 ns");
    $fatal(1, "timeout");
  end

endmodule
